// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM port arbiter.
// Used by ram_port_arbiter and sat_counter.
package ram_arb_pkg;

  localparam int RAM_AW   = 11;
  localparam int RAM_DW   = 32;
  localparam int STALL_CW = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE_F = 2'd1,
    ARB_ISSUE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic owner_t owner_of(arb_state_t s, owner_t prev);
    owner_t o;
    o = prev;
    if (s == ARB_ISSUE_F) o = OWN_F;
    if (s == ARB_ISSUE_D) o = OWN_D;
    return o;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter
  import ram_arb_pkg::*;
#(
  parameter int W = STALL_CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Fetch vs load/store arbiter for the single RAM data port.
// Define ARB_ROUND_ROBIN_EN for round-robin ties (else data wins).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW,
  parameter int CW = STALL_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_w_en,
  output logic [DW-1:0] ram_in,
  input  logic [DW-1:0] ram_out,
  output logic [CW-1:0] f_stall_cnt,
  output logic [CW-1:0] d_stall_cnt
);

  arb_state_t state_q;
  arb_state_t state_d;
  owner_t     last_owner_q;
  owner_t     last_owner_d;
  logic       f_rvalid_q;
  logic       f_rvalid_d;
  logic       d_rvalid_q;
  logic       d_rvalid_d;
  logic       f_el;
  logic       d_el;
  logic       tie_d;

  assign f_gnt = (state_q == ARB_ISSUE_F);
  assign d_gnt = (state_q == ARB_ISSUE_D);

  // gnt masks force a one-cycle gap unless data holds the lock
  assign f_el = f_req & ~f_gnt;
  assign d_el = d_req & (~d_gnt | d_lock);

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_d = (d_lock & d_gnt) | (last_owner_q == OWN_F);
`else
  assign tie_d = 1'b1;
`endif

  always_comb begin
    state_d = ARB_IDLE;
    unique case (1'b1)
      (f_el & ~d_el): state_d = ARB_ISSUE_F;
      (d_el & ~f_el): state_d = ARB_ISSUE_D;
      (f_el & d_el):  state_d = tie_d ? ARB_ISSUE_D
                                      : ARB_ISSUE_F;
      default:        state_d = ARB_IDLE;
    endcase
    last_owner_d = owner_of(state_d, last_owner_q);
    f_rvalid_d   = f_gnt;
    d_rvalid_d   = d_gnt & ~d_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWN_D;
      f_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      f_rvalid_q   <= f_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_w_en = 1'b0;
    ram_in   = '0;
    unique case (state_q)
      ARB_ISSUE_F: begin
        ram_addr = f_addr;
      end
      ARB_ISSUE_D: begin
        ram_addr = d_addr;
        ram_w_en = d_we;
        ram_in   = d_wdata;
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rvalid_q ? ram_out : '0;
  assign d_rdata  = d_rvalid_q ? ram_out : '0;

  sat_counter #(
    .W(CW)
  ) u_f_stall (
    .clk(clk),
    .rst(rst),
    .inc(f_req & ~f_gnt),
    .cnt(f_stall_cnt)
  );

  sat_counter #(
    .W(CW)
  ) u_d_stall (
    .clk(clk),
    .rst(rst),
    .inc(d_req & ~d_gnt),
    .cnt(d_stall_cnt)
  );

endmodule
